lsu_access_ctrl: RTL and testbench

- Memory-access controller sitting directly upstream of data_memory, between the EX/MEM pipeline register and the memory array.
- Accepts one load/store request at a time over a valid/ready handshake. Naturally aligned accesses are forwarded as a single memory operation.
- Misaligned halfword/word accesses are split into sequential byte accesses. Load bytes are reassembled little-endian and sign- or zero-extended.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_access_ctrl_load_extender.sv | 21 ++
 rtl/lsu_access_ctrl.sv | 122 ++++++++++++
 tb/tb_lsu_access_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store access controller.
// Access sizes follow the data_memory load_store_type encoding.
package lsu_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10,
        LS_RSVD = 2'b11
    } ls_type_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_t;

    function automatic logic [2:0] ls_size_bytes(ls_type_t t);
        case (t)
            LS_BYTE: return 3'd1;
            LS_HALF: return 3'd2;
            LS_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Only the two low address bits matter for natural alignment.
    function automatic logic ls_is_aligned(logic [1:0] addr_lo, ls_type_t t);
        case (t)
            LS_BYTE: return 1'b1;
            LS_HALF: return ~addr_lo[0];
            LS_WORD: return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_access_ctrl_load_extender.sv
// Sign/zero extension of a little-endian assembled load value
// to 32 bits according to the original access size.
module load_extender
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  ls_type_t    typ,
    input  logic        zext,
    output logic [31:0] ext
);

    always_comb begin
        ext = data;
        case (typ)
            LS_BYTE: ext = zext ? {24'b0, data[7:0]}  : {{24{data[7]}},  data[7:0]};
            LS_HALF: ext = zext ? {16'b0, data[15:0]} : {{16{data[15]}}, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store access controller in front of data_memory; misaligned
// half/word accesses are broken into sequential byte accesses.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | one memory cycle per byte (split) or one cycle total (aligned)
// RESP   | one-cycle resp_valid pulse, then back to IDLE
module lsu_access_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_type,
    input  logic              req_unsigned,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              resp_split,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        load_store_type,
    output logic              load_unsigned,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_t        state_q, state_nx;
    logic              write_q, uns_q, err_q, split_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, asm_q;
    ls_type_t          type_q;
    logic [2:0]        cnt_q, last_q;
    logic [7:0]        wbyte;
    logic [31:0]       ext;

    ls_type_t   req_t;
    logic       req_rsvd, req_split;
    logic [2:0] req_last;

    assign req_t     = ls_type_t'(req_type);
    assign req_rsvd  = (req_t == LS_RSVD);
    assign req_split = ~req_rsvd & ~ls_is_aligned(req_addr[1:0], req_t);
    assign req_last  = req_split ? (ls_size_bytes(req_t) - 3'd1) : 3'd0;

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_nx = req_rsvd ? RESP : ACCESS;
            ACCESS:  if (cnt_q == last_q) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            type_q  <= LS_BYTE;
            cnt_q   <= 3'd0;
            last_q  <= 3'd0;
        end else begin
            state_q <= state_nx;
            if (state_q == IDLE && req_valid) begin
                write_q <= req_write;
                uns_q   <= req_unsigned;
                err_q   <= req_rsvd;
                split_q <= req_split;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                asm_q   <= '0;
                type_q  <= req_t;
                cnt_q   <= 3'd0;
                last_q  <= req_last;
            end else if (state_q == ACCESS) begin
                if (!write_q) begin
                    if (split_q) asm_q[{cnt_q[1:0], 3'b000} +: 8] <= mem_read_data[7:0];
                    else         asm_q <= mem_read_data;
                end
                if (cnt_q != last_q) cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    load_extender u_ext (
        .data (asm_q),
        .typ  (type_q),
        .zext (uns_q),
        .ext  (ext)
    );

    // Memory-side outputs decode only registered state, so they hold between accesses.
    assign wbyte           = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
    assign req_ready       = (state_q == IDLE);
    assign mem_read        = (state_q == ACCESS) & ~write_q;
    assign mem_write       = (state_q == ACCESS) & write_q;
    assign mem_addr        = addr_q + ADDR_W'(cnt_q);
    assign mem_write_data  = split_q ? {24'b0, wbyte} : wdata_q;
    assign load_store_type = split_q ? LS_BYTE : type_q;
    assign load_unsigned   = split_q | uns_q;

    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) & err_q;
    assign resp_split = (state_q == RESP) & split_q;
    assign resp_rdata = (state_q == RESP && !write_q && !err_q) ? (split_q ? ext : asm_q) : '0;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Directed testbench for lsu_access_ctrl with a byte-addressed
// data_memory model (256 bytes, addresses wrap on the low 8 bits).
module tb_lsu_access_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_type = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_split;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  load_store_type;
    logic        load_unsigned;
    logic [31:0] mem_read_data;

    int total = 0;
    int bad = 0;

    lsu_access_ctrl dut (
        .clk             (clk),
        .rstn            (rstn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_type        (req_type),
        .req_unsigned    (req_unsigned),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .resp_split      (resp_split),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .load_store_type (load_store_type),
        .load_unsigned   (load_unsigned),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    // data_memory model
    logic [7:0] mem [0:255] = '{default: 8'h00};
    int         wr_cycles = 0;
    int         rd_cycles = 0;
    logic [1:0] last_wtype = 2'b00;
    logic [7:0] ra;
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        ra = mem_addr[7:0];
        b0 = mem[ra];
        b1 = mem[ra + 8'd1];
        b2 = mem[ra + 8'd2];
        b3 = mem[ra + 8'd3];
        case (load_store_type)
            2'b00:   mem_read_data = load_unsigned ? {24'h0, b0} : {{24{b0[7]}}, b0};
            2'b01:   mem_read_data = load_unsigned ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: mem_read_data = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            wr_cycles  <= wr_cycles + 1;
            last_wtype <= load_store_type;
            mem[mem_addr[7:0]] <= mem_write_data[7:0];
            if (load_store_type != 2'b00) mem[mem_addr[7:0] + 8'd1] <= mem_write_data[15:8];
            if (load_store_type == 2'b10) begin
                mem[mem_addr[7:0] + 8'd2] <= mem_write_data[23:16];
                mem[mem_addr[7:0] + 8'd3] <= mem_write_data[31:24];
            end
        end
        if (mem_read) rd_cycles <= rd_cycles + 1;
    end

    // One request; lat counts cycles after the accept edge until resp_valid (-1 on timeout).
    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] t, input logic u,
                          output logic [31:0] rd, output logic e, output logic s,
                          output int lat, output int nwr, output int nrd,
                          output logic [1:0] wtype, output int waits);
        int wr0, rd0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        req_type = t; req_unsigned = u;
        wr0 = wr_cycles; rd0 = rd_cycles;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; rd = '0; e = 1'b0; s = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; rd = resp_rdata; e = resp_err; s = resp_split;
                break;
            end
        end
        nwr = wr_cycles - wr0;
        nrd = rd_cycles - rd0;
        wtype = last_wtype;
    endtask

    task automatic test_reset();
        #3;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_split !== 1'b0 || resp_rdata !== 32'h0) begin
            bad++; $display("FAIL rst_resp got=%b%b%b %h exp=000 0", resp_valid, resp_err, resp_split, resp_rdata); end
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0 || mem_write_data !== 32'h0
                     || load_store_type !== 2'b00 || load_unsigned !== 1'b0) begin
            bad++; $display("FAIL rst_mem got=%b%b %h %h %b %b exp=all zero", mem_read, mem_write, mem_addr,
                            mem_write_data, load_store_type, load_unsigned); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_aligned();
        logic [31:0] rd; logic e, s; int lat, nwr, nrd, wt; logic [1:0] wtype;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (lat !== 2) begin bad++; $display("FAIL al_st_lat got=%0d exp=2", lat); end
        total++; if (nwr !== 1 || wtype !== 2'b10) begin bad++; $display("FAIL al_st_wr got=%0d/%b exp=1/10", nwr, wtype); end
        total++; if (rd !== 32'h0 || s !== 1'b0 || e !== 1'b0) begin bad++; $display("FAIL al_st_resp got=%h %b%b exp=0 00", rd, s, e); end
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL al_ld_data got=%h exp=deadbeef", rd); end
        total++; if (lat !== 2 || s !== 1'b0) begin bad++; $display("FAIL al_ld_lat got=%0d split=%b exp=2 0", lat, s); end
        total++; if (nrd !== 1 || nwr !== 0) begin bad++; $display("FAIL al_ld_cycles got=%0d/%0d exp=1/0", nrd, nwr); end
    endtask

    task automatic test_split_store();
        logic [31:0] rd; logic e, s; int lat, nwr, nrd, wt; logic [1:0] wtype;
        do_req(1'b1, 32'h14, 32'h11223344, 2'b10, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        do_req(1'b1, 32'h15, 32'h0000BEEF, 2'b01, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (nwr !== 2 || wtype !== 2'b00) begin bad++; $display("FAIL sp_st_wr got=%0d/%b exp=2/00", nwr, wtype); end
        total++; if (lat !== 3 || s !== 1'b1) begin bad++; $display("FAIL sp_st_lat got=%0d split=%b exp=3 1", lat, s); end
        total++; if (mem[8'h15] !== 8'hEF || mem[8'h16] !== 8'hBE) begin
            bad++; $display("FAIL sp_st_bytes got=%h %h exp=ef be", mem[8'h15], mem[8'h16]); end
        do_req(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (rd !== 32'h11BEEF44) begin bad++; $display("FAIL sp_st_readback got=%h exp=11beef44", rd); end
    endtask

    task automatic test_split_load();
        logic [31:0] rd; logic e, s; int lat, nwr, nrd, wt; logic [1:0] wtype;
        do_req(1'b0, 32'h15, 32'h0, 2'b01, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (rd !== 32'hFFFFBEEF) begin bad++; $display("FAIL sp_ld_half_s got=%h exp=ffffbeef", rd); end
        total++; if (lat !== 3 || s !== 1'b1 || nrd !== 2) begin bad++; $display("FAIL sp_ld_half_timing got=%0d %b %0d exp=3 1 2", lat, s, nrd); end
        do_req(1'b0, 32'h15, 32'h0, 2'b01, 1'b1, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL sp_ld_half_u got=%h exp=0000beef", rd); end
        do_req(1'b0, 32'h13, 32'h0, 2'b10, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (rd !== 32'hBEEF44DE) begin bad++; $display("FAIL sp_ld_word got=%h exp=beef44de", rd); end
        total++; if (lat !== 5 || nrd !== 4 || s !== 1'b1) begin bad++; $display("FAIL sp_ld_word_timing got=%0d %0d %b exp=5 4 1", lat, nrd, s); end
        do_req(1'b0, 32'h16, 32'h0, 2'b00, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (rd !== 32'hFFFFFFBE || lat !== 2 || s !== 1'b0) begin
            bad++; $display("FAIL al_ld_byte got=%h lat=%0d split=%b exp=ffffffbe 2 0", rd, lat, s); end
    endtask

    task automatic test_reserved();
        logic [31:0] rd; logic e, s; int lat, nwr, nrd, wt; logic [1:0] wtype;
        do_req(1'b1, 32'h20, 32'h12345678, 2'b11, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (lat !== 1 || e !== 1'b1) begin bad++; $display("FAIL rsvd_resp got=lat %0d err %b exp=1 1", lat, e); end
        total++; if (nwr !== 0 || nrd !== 0 || rd !== 32'h0) begin
            bad++; $display("FAIL rsvd_noacc got=%0d %0d %h exp=0 0 0", nwr, nrd, rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic e, s; int lat, nwr, nrd, wt; logic [1:0] wtype;
        do_req(1'b1, 32'hFFFFFFFF, 32'h00001234, 2'b01, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (mem[8'hFF] !== 8'h34 || mem[8'h00] !== 8'h12) begin
            bad++; $display("FAIL wrap_st got=%h %h exp=34 12", mem[8'hFF], mem[8'h00]); end
        do_req(1'b0, 32'hFFFFFFFF, 32'h0, 2'b01, 1'b1, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (rd !== 32'h00001234 || lat !== 3) begin bad++; $display("FAIL wrap_ld got=%h lat=%0d exp=00001234 3", rd, lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e, s; int lat, nwr, nrd, wt; logic [1:0] wtype;
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        do_req(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, rd, e, s, lat, nwr, nrd, wtype, wt);
        total++; if (wt !== 0 || rd !== 32'h11BEEF44 || lat !== 2) begin
            bad++; $display("FAIL b2b got=waits %0d data %h lat %0d exp=0 11beef44 2", wt, rd, lat); end
    endtask

    task automatic test_reset_mid();
        int wr0; logic saw_resp;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1D; req_wdata = 32'hCAFEBABE;
        req_type = 2'b10; req_unsigned = 1'b0;
        wr0 = wr_cycles;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        total++; if (mem_write !== 1'b1 || mem_addr !== 32'h1E) begin
            bad++; $display("FAIL mid_cnt1 got=%b %h exp=1 0000001e", mem_write, mem_addr); end
        rstn = 1'b0;
        #1;
        total++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 32'h0 || mem_write_data !== 32'h0
                     || load_store_type !== 2'b00 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL mid_rst_out got=%b%b %h %h %b %b %b exp=00 0 0 00 0 1", mem_write, mem_read,
                            mem_addr, mem_write_data, load_store_type, resp_valid, req_ready); end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        saw_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        total++; if (saw_resp !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL mid_after got=resp %b ready %b exp=0 1", saw_resp, req_ready); end
        total++; if (mem[8'h1D] !== 8'hBE || mem[8'h1F] !== 8'h00 || (wr_cycles - wr0) !== 1) begin
            bad++; $display("FAIL mid_mem got=%h %h writes %0d exp=be 00 1", mem[8'h1D], mem[8'h1F], wr_cycles - wr0); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_split_store();
        test_split_load();
        test_reserved();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
